// File: rtl/ccip_rd_reorder_if.sv
// Channel 0 read path bundle for ccip_rd_reorder.
//   requester side : rd_req_* (read in), rd_rsp_* (in-order data out)
//   host side      : c0tx_* (read request out), c0rx_* (response in)
//   status         : busy, err_unexpected
// slave is the reorder block's view; master is the surrounding logic's view.
interface ccip_rd_reorder_if #(
  parameter int ADDR_W = 42,
  parameter int DATA_W = 512
);
  logic              rd_req_valid;
  logic              rd_req_ready;
  logic [ADDR_W-1:0] rd_req_addr;
  logic              c0tx_valid;
  logic [ADDR_W-1:0] c0tx_addr;
  logic [15:0]       c0tx_mdata;
  logic              c0tx_alm_full;
  logic              c0rx_rsp_valid;
  logic [15:0]       c0rx_mdata;
  logic [DATA_W-1:0] c0rx_data;
  logic              rd_rsp_valid;
  logic              rd_rsp_ready;
  logic [DATA_W-1:0] rd_rsp_data;
  logic              busy;
  logic              err_unexpected;

  modport slave (
    input  rd_req_valid, rd_req_addr, c0tx_alm_full,
           c0rx_rsp_valid, c0rx_mdata, c0rx_data, rd_rsp_ready,
    output rd_req_ready, c0tx_valid, c0tx_addr, c0tx_mdata,
           rd_rsp_valid, rd_rsp_data, busy, err_unexpected
  );

  modport master (
    output rd_req_valid, rd_req_addr, c0tx_alm_full,
           c0rx_rsp_valid, c0rx_mdata, c0rx_data, rd_rsp_ready,
    input  rd_req_ready, c0tx_valid, c0tx_addr, c0tx_mdata,
           rd_rsp_valid, rd_rsp_data, busy, err_unexpected
  );
endinterface

// File: rtl/ccip_rd_reorder.sv
// Read tag tracker / reorder buffer for CCI-P channel 0.
// Requests are issued on c0tx with a ring-allocated tag (head). Responses
// land in a tag-indexed RAM with a valid bit per tag; the oldest tag (tail)
// is retired into a single output register once its data has arrived, so
// data leaves strictly in request order.
// Ports:
//   clk      sole clock
//   reset_n  asynchronous active-low reset
//   bus      ccip_rd_reorder_if.slave (requester, c0tx, c0rx, status)
module ccip_rd_reorder #(
  parameter int NUM_TAGS = 64,
  parameter int ADDR_W   = 42,
  parameter int DATA_W   = 512
) (
  input  logic             clk,
  input  logic             reset_n,
  ccip_rd_reorder_if.slave bus
);
  localparam int TAG_W = $clog2(NUM_TAGS);
  localparam logic [TAG_W:0] FULL = (TAG_W+1)'(NUM_TAGS);

  logic [TAG_W-1:0]    head, tail, rx_tag, rx_dist, tx_tag;
  logic [TAG_W:0]      count;
  logic [NUM_TAGS-1:0] vld;
  logic [DATA_W-1:0]   ram [NUM_TAGS];
  logic [ADDR_W-1:0]   tx_addr;
  logic [DATA_W-1:0]   rsp_data;
  logic                tx_valid, rsp_valid, err;
  logic                accept, rx_legal, rx_write, rx_err, retire;

  // Ready is gated by reset so nothing is accepted while reset is held.
  assign bus.rd_req_ready = reset_n & (count < FULL) & ~bus.c0tx_alm_full;
  assign accept = bus.rd_req_valid & bus.rd_req_ready;

  // A response is legal only for a tag inside the outstanding window
  // [tail, tail+count) that has not already been filled.
  assign rx_tag   = bus.c0rx_mdata[TAG_W-1:0];
  assign rx_dist  = rx_tag - tail;
  assign rx_legal = (bus.c0rx_mdata[15:TAG_W] == '0) &
                    ({1'b0, rx_dist} < count) & ~vld[rx_tag];
  assign rx_write = bus.c0rx_rsp_valid & rx_legal;
  assign rx_err   = bus.c0rx_rsp_valid & ~rx_legal;

  // Retire the oldest line when it has arrived and the output slot frees.
  assign retire = vld[tail] & (~rsp_valid | bus.rd_rsp_ready);

  // Data RAM needs no reset: the valid bits say which entries mean anything.
  always_ff @(posedge clk) begin
    if (rx_write) ram[rx_tag] <= bus.c0rx_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      vld       <= '0;
      tx_valid  <= 1'b0;
      tx_addr   <= '0;
      tx_tag    <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      err       <= 1'b0;
    end else begin
      tx_valid <= accept;
      if (accept) begin
        tx_addr <= bus.rd_req_addr;
        tx_tag  <= head;
        head    <= head + 1'b1;
      end

      count <= count + (TAG_W+1)'(accept) - (TAG_W+1)'(retire);

      // Capture and retire never hit the same bit: a captured tag is not yet valid.
      if (rx_write) vld[rx_tag] <= 1'b1;
      if (retire)   vld[tail]   <= 1'b0;
      if (rx_err)   err         <= 1'b1;

      if (retire) begin
        rsp_valid <= 1'b1;
        rsp_data  <= ram[tail];
        tail      <= tail + 1'b1;
      end else if (bus.rd_rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

  assign bus.c0tx_valid     = tx_valid;
  assign bus.c0tx_addr      = tx_addr;
  assign bus.c0tx_mdata     = {{(16-TAG_W){1'b0}}, tx_tag};
  assign bus.rd_rsp_valid   = rsp_valid;
  assign bus.rd_rsp_data    = rsp_data;
  assign bus.busy           = (count != '0) | rsp_valid;
  assign bus.err_unexpected = err;
endmodule

// File: tb/tb_ccip_rd_reorder.sv
module tb_ccip_rd_reorder;
  localparam int NT = 4;
  localparam int AW = 42;
  localparam int DW = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ccip_rd_reorder_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  ccip_rd_reorder #(.NUM_TAGS(NT), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk     (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  typedef struct {
    int            tag;
    logic [AW-1:0] addr;
  } tx_t;

  // Reference model: requests get tags in issue order modulo NT; data comes
  // back as a function of the address and must leave in issue order.
  logic [DW-1:0] exp_q[$];
  tx_t           tx_q[$];
  int            inflight[$];
  logic [AW-1:0] tag_addr [NT];
  int            n_issued = 0;
  int            n_cmp = 0;
  int            n_err = 0;
  bit            rand_bp = 0;
  logic          prev_v = 1'b0;
  logic          prev_rdy = 1'b0;

  function automatic logic [DW-1:0] dfun(input logic [AW-1:0] a);
    return DW'(a);
  endfunction

  function automatic logic [AW-1:0] rnd_addr();
    return AW'({$urandom(), $urandom()});
  endfunction

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b expected %0b", nm, act, exp);
    end
  endtask

  task automatic chkd(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic reset_model();
    exp_q.delete();
    tx_q.delete();
    inflight.delete();
    n_issued = 0;
    prev_v = 1'b0;
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin : mon_acc
    int t;
    if (rst_n && bus.rd_req_valid && bus.rd_req_ready) begin
      t = n_issued % NT;
      tag_addr[t] = bus.rd_req_addr;
      exp_q.push_back(dfun(bus.rd_req_addr));
      tx_q.push_back('{t, bus.rd_req_addr});
      inflight.push_back(t);
      n_issued++;
    end
  end

  always @(negedge clk) begin : mon_tx
    tx_t e;
    if (rst_n && bus.c0tx_valid) begin
      if (tx_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL c0tx_stray: got c0tx_valid=1 expected 0");
      end else begin
        e = tx_q.pop_front();
        chkd("c0tx_mdata", DW'(bus.c0tx_mdata), DW'(e.tag));
        chkd("c0tx_addr", DW'(bus.c0tx_addr), DW'(e.addr));
      end
    end
  end

  always @(negedge clk) begin : mon_rsp
    if (!rst_n) begin
      prev_v = 1'b0;
    end else begin
      if (prev_v && !prev_rdy) chk1("rsp_hold_valid", bus.rd_rsp_valid, 1'b1);
      if (bus.rd_rsp_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL rsp_stray: got rd_rsp_valid=1 data=%0h expected 0", bus.rd_rsp_data);
        end else begin
          chkd("rsp_data", bus.rd_rsp_data, exp_q[0]);
          if (bus.rd_rsp_ready) void'(exp_q.pop_front());
        end
      end
      prev_v = bus.rd_rsp_valid;
      prev_rdy = bus.rd_rsp_ready;
    end
  end

  always @(posedge clk) begin
    if (rand_bp) begin
      #1;
      bus.rd_rsp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    repeat (50000) @(posedge clk);
    $display("FAIL watchdog: got no finish expected finish within 50000 cycles");
    $fatal(1);
  end

  // ---------------- stimulus tasks ----------------
  task automatic issue(input logic [AW-1:0] a);
    int k;
    k = 0;
    bus.rd_req_valid = 1'b1;
    bus.rd_req_addr  = a;
    while (!bus.rd_req_ready && k < 300) begin step(); k++; end
    if (k >= 300) begin
      n_cmp++; n_err++;
      $display("FAIL issue_timeout: got rd_req_ready=0 expected 1");
    end
    step();
    bus.rd_req_valid = 1'b0;
  endtask

  task automatic respond(input logic [15:0] md, input logic [DW-1:0] d);
    bus.c0rx_rsp_valid = 1'b1;
    bus.c0rx_mdata     = md;
    bus.c0rx_data      = d;
    step();
    bus.c0rx_rsp_valid = 1'b0;
  endtask

  task automatic respond_tag(input int t);
    for (int i = 0; i < inflight.size(); i++)
      if (inflight[i] == t) begin inflight.delete(i); break; end
    respond(16'(t), dfun(tag_addr[t]));
  endtask

  task automatic respond_all_random();
    int i;
    while (inflight.size() != 0) begin
      i = int'($urandom_range(0, inflight.size() - 1));
      respond_tag(inflight[i]);
      idle(int'($urandom_range(0, 2)));
    end
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || bus.rd_rsp_valid) && k < 500) begin step(); k++; end
    chk1("drain_done", 1'(k < 500), 1'b1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    reset_model();
    #1;
    chk1("rst_ready", bus.rd_req_ready, 1'b0);
    chk1("rst_c0tx_valid", bus.c0tx_valid, 1'b0);
    chk1("rst_rsp_valid", bus.rd_rsp_valid, 1'b0);
    chk1("rst_busy", bus.busy, 1'b0);
    chk1("rst_err", bus.err_unexpected, 1'b0);
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int r[4];
    int exp_t;
    bus.rd_req_valid   = 1'b0;
    bus.rd_req_addr    = '0;
    bus.c0tx_alm_full  = 1'b0;
    bus.c0rx_rsp_valid = 1'b0;
    bus.c0rx_mdata     = '0;
    bus.c0rx_data      = '0;
    bus.rd_rsp_ready   = 1'b1;

    // Reset state
    #2;
    chk1("init_ready", bus.rd_req_ready, 1'b0);
    chkd("init_c0tx_addr", DW'(bus.c0tx_addr), '0);
    chkd("init_c0tx_mdata", DW'(bus.c0tx_mdata), '0);
    chkd("init_rsp_data", bus.rd_rsp_data, '0);
    chk1("init_busy", bus.busy, 1'b0);
    chk1("init_err", bus.err_unexpected, 1'b0);
    step(); step();
    rst_n = 1'b1;
    step();
    chk1("post_rst_ready", bus.rd_req_ready, 1'b1);

    // Ordered: 4 reads, responses in tag order, 2-cycle response latency
    for (int i = 0; i < 4; i++) issue(AW'(42'h100) + AW'(i));
    idle(2);
    chk1("full_ready", bus.rd_req_ready, 1'b0);
    chk1("full_busy", bus.busy, 1'b1);
    exp_t = inflight.pop_front();
    bus.c0rx_rsp_valid = 1'b1;
    bus.c0rx_mdata     = 16'(exp_t);
    bus.c0rx_data      = dfun(tag_addr[exp_t]);
    @(negedge clk); chk1("lat_c0", bus.rd_rsp_valid, 1'b0);
    step();
    bus.c0rx_rsp_valid = 1'b0;
    @(negedge clk); chk1("lat_c1", bus.rd_rsp_valid, 1'b0);
    step();
    @(negedge clk); chk1("lat_c2", bus.rd_rsp_valid, 1'b1);
    step();
    for (int i = 0; i < 3; i++) respond_tag(inflight[0]);
    wait_drain();
    chk1("ordered_busy", bus.busy, 1'b0);

    // Reorder: responses 3,1,0,2
    for (int i = 0; i < 4; i++) issue(rnd_addr());
    for (int i = 0; i < 4; i++) r[i] = inflight[i];
    respond_tag(r[3]);
    respond_tag(r[1]);
    idle(3);
    chk1("reorder_hold", bus.rd_rsp_valid, 1'b0);
    respond_tag(r[0]);
    step(); @(negedge clk); chk1("reorder_b2b0", bus.rd_rsp_valid, 1'b1);
    step(); @(negedge clk); chk1("reorder_b2b1", bus.rd_rsp_valid, 1'b1);
    step(); @(negedge clk); chk1("reorder_gap", bus.rd_rsp_valid, 1'b0);
    step();
    respond_tag(r[2]);
    wait_drain();

    // Full and wrap
    for (int i = 0; i < 4; i++) issue(rnd_addr());
    idle(1);
    chk1("wrap_full_ready", bus.rd_req_ready, 1'b0);
    respond_tag(inflight[0]);
    idle(2);
    chk1("wrap_ready_after_retire", bus.rd_req_ready, 1'b1);
    exp_t = n_issued % NT;
    issue(rnd_addr());
    chkd("wrap_next_tag", DW'(bus.c0tx_mdata), DW'(exp_t));
    respond_all_random();
    wait_drain();
    rand_bp = 1'b1;
    repeat (10) begin
      for (int i = 0; i < 4; i++) issue(rnd_addr());
      respond_all_random();
    end
    wait_drain();
    rand_bp = 1'b0;
    step();
    bus.rd_rsp_ready = 1'b1;
    wait_drain();
    idle(2);
    chk1("wrap_busy", bus.busy, 1'b0);
    chk1("wrap_ready", bus.rd_req_ready, 1'b1);
    chkd("wrap_exp_empty", DW'(exp_q.size()), '0);

    // Backpressure: almost-full blocks issue
    bus.c0tx_alm_full = 1'b1;
    step();
    chk1("almfull_ready", bus.rd_req_ready, 1'b0);
    bus.rd_req_valid = 1'b1;
    bus.rd_req_addr  = rnd_addr();
    idle(4);
    chk1("almfull_no_tx", bus.c0tx_valid, 1'b0);
    bus.rd_req_valid = 1'b0;
    step();
    bus.c0tx_alm_full = 1'b0;
    step();
    chk1("almfull_release", bus.rd_req_ready, 1'b1);
    // Backpressure: 3 buffered lines held, then 3 consecutive
    bus.rd_rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) issue(rnd_addr());
    for (int i = 0; i < 3; i++) respond_tag(inflight[0]);
    idle(4);
    @(negedge clk);
    chk1("bp_valid", bus.rd_rsp_valid, 1'b1);
    chkd("bp_data", bus.rd_rsp_data, exp_q[0]);
    step();
    bus.rd_rsp_ready = 1'b1;
    @(negedge clk); chk1("bp_out0", bus.rd_rsp_valid, 1'b1);
    step(); @(negedge clk); chk1("bp_out1", bus.rd_rsp_valid, 1'b1);
    step(); @(negedge clk); chk1("bp_out2", bus.rd_rsp_valid, 1'b1);
    step(); @(negedge clk); chk1("bp_out3", bus.rd_rsp_valid, 1'b0);
    step();
    chkd("bp_exp_empty", DW'(exp_q.size()), '0);

    // Errors: response with nothing outstanding
    chk1("err_clean", bus.err_unexpected, 1'b0);
    respond(16'h0005, DW'(64'hBAD0_BAD0));
    idle(3);
    chk1("err_idle", bus.err_unexpected, 1'b1);
    chk1("err_idle_noout", bus.rd_rsp_valid, 1'b0);
    do_reset();
    // Tag just outside the outstanding window
    issue(rnd_addr());
    respond(16'h0001, DW'(64'hBAD1));
    idle(2);
    chk1("err_window", bus.err_unexpected, 1'b1);
    respond_tag(inflight[0]);
    wait_drain();
    do_reset();
    // Nonzero upper mdata bit with an otherwise legal tag
    issue(rnd_addr());
    respond(16'h8000, DW'(64'hBAD2));
    idle(2);
    chk1("err_mdata_hi", bus.err_unexpected, 1'b1);
    respond_tag(inflight[0]);
    wait_drain();
    do_reset();
    // Duplicate response must not overwrite the first data
    issue(rnd_addr());
    issue(rnd_addr());
    r[0] = inflight[0];
    r[1] = inflight[1];
    respond_tag(r[1]);
    respond(16'(r[1]), ~dfun(tag_addr[r[1]]));
    idle(2);
    chk1("err_dup", bus.err_unexpected, 1'b1);
    respond_tag(r[0]);
    wait_drain();
    do_reset();

    // Reset mid-flight
    bus.rd_rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) issue(rnd_addr());
    respond_tag(inflight[0]);
    idle(3);
    chk1("mid_pre_valid", bus.rd_rsp_valid, 1'b1);
    bus.rd_req_valid = 1'b1;
    bus.rd_req_addr  = rnd_addr();
    @(posedge clk);
    #3;
    chk1("mid_pre_c0tx", bus.c0tx_valid, 1'b1);
    rst_n = 1'b0;
    reset_model();
    #1;
    chk1("mid_c0tx_valid", bus.c0tx_valid, 1'b0);
    chkd("mid_c0tx_addr", DW'(bus.c0tx_addr), '0);
    chkd("mid_c0tx_mdata", DW'(bus.c0tx_mdata), '0);
    chk1("mid_rsp_valid", bus.rd_rsp_valid, 1'b0);
    chkd("mid_rsp_data", bus.rd_rsp_data, '0);
    chk1("mid_busy", bus.busy, 1'b0);
    chk1("mid_ready", bus.rd_req_ready, 1'b0);
    bus.rd_req_valid = 1'b0;
    step(); step();
    rst_n = 1'b1;
    bus.rd_rsp_ready = 1'b1;
    step();
    respond(16'h0001, DW'(64'hBAD3));
    idle(3);
    chk1("mid_late_err", bus.err_unexpected, 1'b1);
    chk1("mid_late_noout", bus.rd_rsp_valid, 1'b0);
    issue(rnd_addr());
    chkd("mid_new_tag", DW'(bus.c0tx_mdata), '0);
    respond_tag(inflight[0]);
    wait_drain();
    idle(2);
    chk1("mid_final_busy", bus.busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
